// File: rtl/ram_bist_master.sv
// March BIST initiator for single_port_sync_ram: write-up, read-up, inverted write-down, inverted read-down.
// Optional macro RAM_BIST_STOP_ON_FAIL_EN ends the test at the first mismatch.
module ram_bist_master #(
  parameter int          ADDR_WIDTH = 4,
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 16,
  parameter logic [31:0] SEED       = 32'hA5A5_5A5A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // state    | meaning
  // IDLE     | RAM port released, waiting for start
  // WR_UP    | write P(a), a = 0..DEPTH-1
  // RD_UP    | read back, a = 0..DEPTH-1
  // DRAIN_UP | port idle, compare last ascending read
  // WR_DN    | write ~P(a), a = DEPTH-1..0
  // RD_DN    | read back, a = DEPTH-1..0
  // DRAIN_DN | port idle, compare last descending read
  // DONE     | one-cycle done pulse with pass result
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_UP    = 3'd1;
  localparam logic [2:0] S_RD_UP    = 3'd2;
  localparam logic [2:0] S_DRAIN_UP = 3'd3;
  localparam logic [2:0] S_WR_DN    = 3'd4;
  localparam logic [2:0] S_RD_DN    = 3'd5;
  localparam logic [2:0] S_DRAIN_DN = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] W_SEED = DATA_WIDTH'(SEED);

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    return W_SEED ^ DATA_WIDTH'(a);
  endfunction

  logic [2:0]            r_state;
  logic                  r_busy, r_done, r_pass, r_err_seen;
  logic [ADDR_WIDTH-1:0] r_fail_addr, r_cmp_addr, r_mem_addr;
  logic [DATA_WIDTH-1:0] r_fail_exp, r_fail_got, r_cmp_exp, r_mem_wdata;
  logic                  r_mem_cs, r_mem_we, r_mem_oe, r_cmp_vld;

  logic                  w_mismatch;
  logic [ADDR_WIDTH-1:0] w_addr_inc, w_addr_dec;

  assign w_mismatch = r_cmp_vld && (mem_rdata != r_cmp_exp);
  assign w_addr_inc = r_mem_addr + A_ONE;
  assign w_addr_dec = r_mem_addr - A_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_seen  <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_exp   <= '0;
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_oe    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      // Each issued read registers what it should return; checked next cycle.
      r_cmp_vld <= r_mem_oe;
      if (r_mem_oe) begin
        r_cmp_addr <= r_mem_addr;
        r_cmp_exp  <= (r_state == S_RD_DN) ? ~pat(r_mem_addr) : pat(r_mem_addr);
      end
      if (w_mismatch && !r_err_seen) begin
        r_err_seen  <= 1'b1;
        r_fail_addr <= r_cmp_addr;
        r_fail_exp  <= r_cmp_exp;
        r_fail_got  <= mem_rdata;
      end
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state     <= S_WR_UP;
          r_busy      <= 1'b1;
          r_pass      <= 1'b0;
          r_err_seen  <= 1'b0;
          r_fail_addr <= '0;
          r_fail_exp  <= '0;
          r_fail_got  <= '0;
          r_mem_cs    <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= '0;
          r_mem_wdata <= pat('0);
        end
        S_WR_UP: if (r_mem_addr == A_LAST) begin
          r_state     <= S_RD_UP;
          r_mem_we    <= 1'b0;
          r_mem_oe    <= 1'b1;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
        end else begin
          r_mem_addr  <= w_addr_inc;
          r_mem_wdata <= pat(w_addr_inc);
        end
        S_RD_UP: if (r_mem_addr == A_LAST) begin
          r_state    <= S_DRAIN_UP;
          r_mem_cs   <= 1'b0;
          r_mem_oe   <= 1'b0;
          r_mem_addr <= '0;
        end else begin
          r_mem_addr <= w_addr_inc;
        end
        S_DRAIN_UP: begin
          r_state     <= S_WR_DN;
          r_mem_cs    <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= A_LAST;
          r_mem_wdata <= ~pat(A_LAST);
        end
        S_WR_DN: if (r_mem_addr == '0) begin
          r_state     <= S_RD_DN;
          r_mem_we    <= 1'b0;
          r_mem_oe    <= 1'b1;
          r_mem_addr  <= A_LAST;
          r_mem_wdata <= '0;
        end else begin
          r_mem_addr  <= w_addr_dec;
          r_mem_wdata <= ~pat(w_addr_dec);
        end
        S_RD_DN: if (r_mem_addr == '0) begin
          r_state  <= S_DRAIN_DN;
          r_mem_cs <= 1'b0;
          r_mem_oe <= 1'b0;
        end else begin
          r_mem_addr <= w_addr_dec;
        end
        S_DRAIN_DN: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= !(r_err_seen || w_mismatch);
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef RAM_BIST_STOP_ON_FAIL_EN
      // Abort: release the port in the same edge the mismatch is seen.
      if (w_mismatch && r_busy) begin
        r_state     <= S_DONE;
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
        r_pass      <= 1'b0;
        r_cmp_vld   <= 1'b0;
        r_mem_cs    <= 1'b0;
        r_mem_we    <= 1'b0;
        r_mem_oe    <= 1'b0;
        r_mem_wdata <= '0;
      end
`endif
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_addr = r_fail_addr;
  assign fail_exp  = r_fail_exp;
  assign fail_got  = r_fail_got;
  assign mem_cs    = r_mem_cs;
  assign mem_we    = r_mem_we;
  assign mem_oe    = r_mem_oe;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_ram_bist_master.sv
// Bench for ram_bist_master: faulty behavioural RAM, per-cycle reference model, randomized fault runs.
module tb_ram_bist_master;

`ifdef RAM_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  localparam logic [31:0] SEED = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, pass, mem_cs, mem_we, mem_oe;
  logic [3:0]  fail_addr, mem_addr;
  logic [31:0] fail_exp, fail_got, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic start_1;
  logic busy_1, done_1, pass_1, cs_1, we_1, oe_1;
  logic [3:0]  faddr_1, addr_1;
  logic [31:0] fexp_1, fgot_1, wdata_1;
  logic [31:0] rdata_1 = '0;
  logic [31:0] mem1 = '0;

  always #5 clk = ~clk;

  ram_bist_master dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  ram_bist_master #(.DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_1), .busy(busy_1), .done(done_1), .pass(pass_1),
    .fail_addr(faddr_1), .fail_exp(fexp_1), .fail_got(fgot_1),
    .mem_cs(cs_1), .mem_we(we_1), .mem_oe(oe_1), .mem_addr(addr_1),
    .mem_wdata(wdata_1), .mem_rdata(rdata_1));

  // Faulty RAM: stuck-at masks applied on read.
  logic [31:0] ram [16];
  logic [31:0] sa0 [16];
  logic [31:0] sa1 [16];
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_cs && mem_oe) mem_rdata <= (ram[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
    if (cs_1 && we_1) mem1 <= wdata_1;
    if (cs_1 && oe_1) rdata_1 <= mem1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int k;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s k=%0d got=%h exp=%h", nm, k, got, expv);
    end
  endtask

  // Reference model: one expected record per cycle, cycle 0 = start pulse.
  typedef struct {
    bit cs, we, oe, busy, done, res;
    bit [3:0] addr;
    bit [31:0] wdata;
  } exp_t;
  exp_t ex[$];
  int dk_model;
  bit exp_pass;
  logic [3:0]  exp_faddr;
  logic [31:0] exp_fexp, exp_fgot;

  function automatic logic [31:0] P(input int a);
    return SEED ^ 32'(a);
  endfunction

  function automatic void push(bit cs, bit we, bit oe, int a, logic [31:0] wd, bit b, bit d, bit r);
    exp_t e;
    e.cs = cs; e.we = we; e.oe = oe; e.addr = 4'(a); e.wdata = wd;
    e.busy = b; e.done = d; e.res = r;
    ex.push_back(e);
  endfunction

  function automatic void build_model();
    logic [31:0] mm [16];
    logic [31:0] rd;
    int fk;
    ex.delete();
    fk = -1;
    exp_faddr = '0; exp_fexp = '0; exp_fgot = '0;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 16; a++) begin mm[a] = P(a); push(1, 1, 0, a, mm[a], 1, 0, 0); end
    for (int a = 0; a < 16; a++) begin
      push(1, 0, 1, a, 0, 1, 0, 0);
      rd = (mm[a] | sa1[a]) & ~sa0[a];
      if (rd != mm[a] && fk < 0) begin
        fk = ex.size(); exp_faddr = 4'(a); exp_fexp = mm[a]; exp_fgot = rd;
      end
    end
    push(0, 0, 0, 0, 0, 1, 0, 0);
    for (int a = 15; a >= 0; a--) begin mm[a] = ~P(a); push(1, 1, 0, a, mm[a], 1, 0, 0); end
    for (int a = 15; a >= 0; a--) begin
      push(1, 0, 1, a, 0, 1, 0, 0);
      rd = (mm[a] | sa1[a]) & ~sa0[a];
      if (rd != mm[a] && fk < 0) begin
        fk = ex.size(); exp_faddr = 4'(a); exp_fexp = mm[a]; exp_fgot = rd;
      end
    end
    push(0, 0, 0, 0, 0, 1, 0, 0);
    if (STOP && fk >= 0) while (ex.size() > fk + 1) void'(ex.pop_back());
    exp_pass = (fk < 0);
    dk_model = ex.size();
    push(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) push(0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  // Compare process and observations for literal checks.
  bit run_active = 0, run_done = 0;
  int t0;
  int done_k, last_cs_k, busy_cnt, wr_cnt;
  logic [31:0] wd3;
  bit obs_pass;
  logic [3:0]  obs_faddr;
  logic [31:0] obs_fexp, obs_fgot;
  exp_t e;

  always @(negedge clk) begin
    if (run_active) begin
      k = cyc - t0;
      if (k >= 0 && k < ex.size()) begin
        e = ex[k];
        check("busy", busy, e.busy);
        check("done", done, e.done);
        check("mem_cs", mem_cs, e.cs);
        check("mem_we", mem_we, e.we);
        check("mem_oe", mem_oe, e.oe);
        if (e.cs) check("mem_addr", mem_addr, e.addr);
        if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        if (e.res) begin
          check("pass", pass, exp_pass);
          check("fail_addr", fail_addr, exp_faddr);
          check("fail_exp", fail_exp, exp_fexp);
          check("fail_got", fail_got, exp_fgot);
        end
        if (k == 1) begin
          check("start_clr_pass", pass, 0);
          check("start_clr_faddr", fail_addr, 0);
          check("start_clr_fexp", fail_exp, 0);
          check("start_clr_fgot", fail_got, 0);
        end
        if (done && done_k < 0) begin
          done_k = k; obs_pass = pass; obs_faddr = fail_addr; obs_fexp = fail_exp; obs_fgot = fail_got;
        end
        if (mem_cs) last_cs_k = k;
        if (busy) busy_cnt++;
        if (mem_cs && mem_we && k <= 16) begin
          wr_cnt++;
          if (mem_addr == 4'd3) wd3 = mem_wdata;
        end
        if (k == ex.size() - 1) run_done = 1;
      end
    end
  end

  task automatic run_test(input int x1, input bit x_done, input int rst_at);
    int kk, guard;
    @(negedge clk);
    build_model();
    done_k = -1; last_cs_k = -1; busy_cnt = 0; wr_cnt = 0; wd3 = '0;
    run_done = 0; t0 = cyc; start = 1; run_active = 1;
    @(negedge clk);
    start = 0;
    guard = 0;
    while (!run_done && guard < 200) begin
      @(negedge clk);
      guard++;
      kk = cyc - t0;
      start = ((kk == x1) && (kk < dk_model)) || (x_done && kk == dk_model);
      if (kk == rst_at) begin
        rst = 1; run_active = 0;
        break;
      end
    end
    start = 0;
    run_active = 0;
    if (rst_at >= 0) begin
      @(negedge clk);
      rst = 0;
      check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_pass", pass, 0);
      check("rst_cs", mem_cs, 0); check("rst_we", mem_we, 0); check("rst_oe", mem_oe, 0);
      check("rst_addr", mem_addr, 0); check("rst_wdata", mem_wdata, 0);
      check("rst_faddr", fail_addr, 0); check("rst_fexp", fail_exp, 0); check("rst_fgot", fail_got, 0);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("post_rst_cs", mem_cs, 0);
        check("post_rst_busy", busy, 0);
      end
    end else if (!run_done) begin
      checks++; failures++;
      $display("FAIL timeout run got=no_done exp=done_within_200");
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 16; i++) begin sa0[i] = '0; sa1[i] = '0; end
  endtask

  initial begin
    int nf, fa, fb, kd;
    bit seen_bad_addr;
    rst = 1; start = 0; start_1 = 0;
    clear_faults();
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_cs", mem_cs, 0);
    check("reset_faddr", fail_addr, 0);
    rst = 0;
    @(negedge clk);

    // Fault-free run
    run_test(-1, 0, -1);
    check("t1_done_cycle", done_k, 67);
    check("t1_busy_cycles", busy_cnt, 66);
    check("t1_wr_count", wr_cnt, 16);
    check("t1_wdata_a3", wd3, 32'hA5A55A59);
    check("t1_pass", obs_pass, 1);
    check("t1_faddr", obs_faddr, 0);

    // Extra starts at cycle 10 and in the DONE cycle are ignored
    run_test(10, 1, -1);
    check("t5_done_cycle", done_k, 67);
    check("t5_pass", obs_pass, 1);

    // Bit 0 stuck-at-1 at addr 5
    sa1[5] = 32'h1;
    run_test(-1, 0, -1);
    check("t2_pass", obs_pass, 0);
    check("t2_faddr", obs_faddr, 4'd5);
    check("t2_fexp", obs_fexp, 32'h5A5AA5A0);
    check("t2_fgot", obs_fgot, 32'h5A5AA5A1);
    check("t2_done_cycle", done_k, STOP ? 62 : 67);
    check("t2_last_cs", last_cs_k, STOP ? 61 : 65);

    // Two faults: addr 2 bit 4 stuck-at-0, addr 9 bit 31 stuck-at-1
    clear_faults();
    sa0[2] = 32'h10; sa1[9] = 32'h8000_0000;
    run_test(-1, 0, -1);
    check("t3_pass", obs_pass, 0);
    check("t3_faddr", obs_faddr, 4'd2);
    check("t3_fexp", obs_fexp, 32'hA5A55A58);
    check("t3_fgot", obs_fgot, 32'hA5A55A48);

    // Reset mid-test, then a clean rerun
    clear_faults();
    run_test(-1, 0, 20);
    run_test(-1, 0, -1);
    check("t4_pass", obs_pass, 1);

    // Randomized faults and stray starts
    for (int r = 0; r < 8; r++) begin
      clear_faults();
      nf = $urandom_range(0, 2);
      for (int f = 0; f < nf; f++) begin
        fa = $urandom_range(0, 15);
        fb = $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) sa1[fa][fb] = 1'b1;
        else sa0[fa][fb] = 1'b1;
      end
      run_test($urandom_range(1, 60), 1'($urandom_range(0, 1)), -1);
    end
    clear_faults();
    run_test(-1, 0, $urandom_range(2, 60));
    run_test(-1, 0, -1);

    // DEPTH=1 instance
    @(negedge clk);
    start_1 = 1;
    kd = -1;
    seen_bad_addr = 0;
    for (int i = 1; i <= 20 && kd < 0; i++) begin
      @(negedge clk);
      start_1 = 0;
      if (cs_1 && addr_1 != 4'd0) seen_bad_addr = 1;
      if (done_1) kd = i;
    end
    start_1 = 0;
    k = kd;
    check("d1_done_cycle", kd, 7);
    check("d1_pass", pass_1, 1);
    check("d1_addr_range", seen_bad_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bist_master.md
Name: ram_bist_master

Overview:
Built-in self-test initiator for single_port_sync_ram. It drives the RAM's chip select, write enable, output enable, address and write-data pins, and checks the synchronous read data. A start pulse runs a four-pass march: write-up, read-up, inverted write-down, inverted read-down. It reports pass/fail with first-failure capture. The block sits beside the RAM instance and owns the RAM port while busy.

Parameters:
ADDR_WIDTH, 4, RAM address width
DATA_WIDTH, 32, RAM data width
DEPTH, 16, number of words tested; must satisfy DEPTH <= 2**ADDR_WIDTH
SEED, 32'hA5A5_5A5A, base pattern, truncated or zero-extended to DATA_WIDTH

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  reset, synchronous and active-high
start  input  1  single-cycle pulse; begins test when idle
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle pulse in DONE state
pass  output  1  result; valid from done until the next start
fail_addr  output  ADDR_WIDTH  address of first mismatch
fail_exp  output  DATA_WIDTH  expected word at first mismatch
fail_got  output  DATA_WIDTH  read word at first mismatch
mem_cs  output  1  RAM chip select
mem_we  output  1  RAM write enable
mem_oe  output  1  RAM output enable
mem_addr  output  ADDR_WIDTH  RAM address
mem_wdata  output  DATA_WIDTH  RAM write data
mem_rdata  input  DATA_WIDTH  RAM read data; valid the cycle after the read is issued

Behaviour:
- Pattern: P(a) = SEED ^ zero-extended a. Inverted passes use ~P(a).
- Reset, when rst is high at a clock edge:
  - state goes to IDLE.
  - busy, done, mem_cs, mem_we and mem_oe go to 0.
  - mem_addr, mem_wdata, fail_addr, fail_exp and fail_got go to 0.
  - pass goes to 0.
  - Reset mid-test aborts immediately, with no further RAM accesses.
- All outputs are registered.
- States and transitions:
  - IDLE: RAM port inactive (cs=we=oe=0). start=1 clears pass and the fail_* outputs, sets busy, and moves to WR_UP.
  - WR_UP: cs=1, we=1, oe=0. addr goes 0..DEPTH-1 with wdata=P(addr), one word per cycle. Moves to RD_UP after DEPTH-1.
  - RD_UP: cs=1, we=0, oe=1. addr goes 0..DEPTH-1. Moves to DRAIN_UP after DEPTH-1.
  - DRAIN_UP: one cycle with cs=0 that compares the last read. Moves to WR_DN.
  - WR_DN: addr goes DEPTH-1 down to 0 with wdata=~P(addr). Moves to RD_DN after 0.
  - RD_DN: addr goes DEPTH-1 down to 0. Moves to DRAIN_DN after 0.
  - DRAIN_DN: one cycle, then DONE.
  - DONE: done=1, busy=0, pass = no mismatch seen. Returns to IDLE the next cycle.
- Compare pipeline: each read issue registers the expected word and address. In the following cycle mem_rdata is compared against them.
- First-failure capture: the first mismatch loads fail_addr, fail_exp and fail_got. Later mismatches do not overwrite them.
- Latency: the start edge is cycle 0; DONE/done occur in cycle 4*DEPTH+3 (67 for DEPTH=16).
- Boundaries:
  - start while busy or in DONE is ignored.
  - start and rst high together: rst wins.
  - The address counter does not wrap past DEPTH-1 or 0. Terminal compares are exact, so no access occurs outside 0..DEPTH-1.
  - DEPTH=1 is legal and gives done at cycle 7.

Optional Feature:
RAM_BIST_STOP_ON_FAIL_EN:
- Defined: the first mismatch forces the next state to DONE with pass=0. No further RAM accesses are issued; cs=we=oe=0 from that cycle.
- Undefined: the test always runs to completion, with capture as above.

Test Plan:
- Fault-free behavioural 16x32 RAM, start pulse:
  - busy high cycles 1..66, done in cycle 67, pass=1, fail_*=0.
  - Write-up traffic: 16 writes with wdata at addr 3 = 32'hA5A55A59.
- Bit 0 stuck-at-1 at addr 5 (macro undefined):
  - Read-up passes at addr 5.
  - Read-down fails: pass=0, fail_addr=5, fail_exp=32'h5A5AA5A0, fail_got=32'h5A5AA5A1, done in cycle 67.
- Same fault with RAM_BIST_STOP_ON_FAIL_EN:
  - read of addr 5 issued cycle 60, compare cycle 61, done in cycle 62.
  - no cs after cycle 61.
- Two faults, addr 2 bit 4 stuck-at-0 and addr 9 bit 31 stuck-at-1:
  - Read-up sees addr 2 first and the capture shows addr 2.
  - fail_exp=32'hA5A55A58, fail_got=32'hA5A55A48.
- Reset mid-test:
  - rst at cycle 20 gives all outputs 0 next cycle and no further RAM access.
  - A new start then completes with pass=1.
- start pulsed again at cycle 10 and in the DONE cycle:
  - ignored; the single run finishes at cycle 67.
  - pass is cleared only by a later start accepted in IDLE.
